// File: rtl/juhe_frame_builder.sv
// ---------------------------------------------------------------------------
// juhe_frame_builder
//
// Pulls 1-4 byte chunks from the byte-repacking FIFO and packs them into
// aggregated frames on a 32-bit valid/ready stream. Each frame is sent in
// this order:
//   - one header word {HDR_MAGIC, seq[7:0], len[7:0]}
//   - payload words carrying exactly len bytes, left-justified
//   - optionally, a checksum trailer word
//
// Build option:
//   JFB_CHECKSUM_EN  When defined, a trailer word {TRL_MAGIC, sum16} follows
//                    the payload and carries m_last. sum16 is the 16-bit
//                    wrapping sum of the frame's payload bytes. When not
//                    defined, the last payload word carries m_last.
//
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset
//   enable           start new frames (a running frame always completes)
//   cfg_frame_len    payload bytes per frame, sampled in IDLE (0 = no frame)
//   fifo_level       valid byte count in the FIFO
//   fifo_rd_en       one-cycle read pulse to the FIFO
//   fifo_rd_bytes    chunk size of the read (1..4), 0 when not reading
//   fifo_dout        FIFO data, valid the cycle after fifo_rd_en; byte0 in [31:24]
//   m_data, m_keep   output word and its MSB-first byte mask
//   m_valid, m_last  output valid; last word of the frame
//   m_ready          downstream accept
//   frame_cnt        frames completed since reset (wraps)
// ---------------------------------------------------------------------------
module juhe_frame_builder #(
  parameter logic [15:0] HDR_MAGIC = 16'hA5C3,
  parameter int          LEN_W     = 8
`ifdef JFB_CHECKSUM_EN
  ,
  parameter logic [15:0] TRL_MAGIC = 16'h5A3C
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [LEN_W-1:0] cfg_frame_len,
  input  logic [4:0]       fifo_level,
  output logic             fifo_rd_en,
  output logic [3:0]       fifo_rd_bytes,
  input  logic [31:0]      fifo_dout,
  output logic [31:0]      m_data,
  output logic [3:0]       m_keep,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic [15:0]      frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_REQ,
    S_WAIT,
    S_OUT
`ifdef JFB_CHECKSUM_EN
    ,
    S_TRL
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [2:0]       n_q, n_d;
  logic [7:0]       seq_q, seq_d;
  logic [31:0]      data_q, data_d;
  logic [3:0]       keep_q, keep_d;
  logic             last_q, last_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
`ifdef JFB_CHECKSUM_EN
  logic [15:0]      sum_q, sum_d;
`endif

  // Chunk size for the next read: never more than what is left of the frame.
  logic [2:0]       n_req;
  logic [3:0]       chunk_keep;
  logic [31:0]      chunk_data;
  logic [LEN_W-1:0] rem_after;

  always_comb begin
    n_req = (rem_q >= LEN_W'(4)) ? 3'd4 : rem_q[2:0];
  end

  // Keep mask of the chunk in flight, and the FIFO word with the bytes
  // beyond the chunk zeroed (the FIFO may present stale bytes there).
  always_comb begin
    case (n_q)
      3'd1:    chunk_keep = 4'b1000;
      3'd2:    chunk_keep = 4'b1100;
      3'd3:    chunk_keep = 4'b1110;
      default: chunk_keep = 4'b1111;
    endcase
    chunk_data = fifo_dout & {{8{chunk_keep[3]}}, {8{chunk_keep[2]}},
                              {8{chunk_keep[1]}}, {8{chunk_keep[0]}}};
    rem_after  = rem_q - LEN_W'(n_q);
  end

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    n_d           = n_q;
    seq_d         = seq_q;
    data_d        = data_q;
    keep_d        = keep_q;
    last_d        = last_q;
    frame_cnt_d   = frame_cnt_q;
`ifdef JFB_CHECKSUM_EN
    sum_d         = sum_q;
`endif
    fifo_rd_en    = 1'b0;
    fifo_rd_bytes = 4'd0;
    m_valid       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable && (cfg_frame_len != '0)) begin
          rem_d   = cfg_frame_len;
          data_d  = {HDR_MAGIC, seq_q, 8'(cfg_frame_len)};
          keep_d  = 4'hF;
          last_d  = 1'b0;
`ifdef JFB_CHECKSUM_EN
          sum_d   = 16'd0;
`endif
          state_d = S_HDR;
        end
      end

      S_HDR: begin
        m_valid = 1'b1;
        if (m_ready) begin
          seq_d   = seq_q + 8'd1;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        // Only whole chunks are read; stall until the FIFO holds enough.
        if (fifo_level >= {2'b00, n_req}) begin
          fifo_rd_en    = 1'b1;
          fifo_rd_bytes = {1'b0, n_req};
          n_d           = n_req;
          state_d       = S_WAIT;
        end
      end

      S_WAIT: begin
        data_d  = chunk_data;
        keep_d  = chunk_keep;
        rem_d   = rem_after;
`ifdef JFB_CHECKSUM_EN
        last_d  = 1'b0;
        sum_d   = sum_q + 16'(chunk_data[31:24]) + 16'(chunk_data[23:16])
                        + 16'(chunk_data[15:8])  + 16'(chunk_data[7:0]);
`else
        last_d  = (rem_after == '0);
`endif
        state_d = S_OUT;
      end

      S_OUT: begin
        m_valid = 1'b1;
        if (m_ready) begin
          if (rem_q != '0) begin
            state_d = S_REQ;
          end else begin
`ifdef JFB_CHECKSUM_EN
            data_d  = {TRL_MAGIC, sum_q};
            keep_d  = 4'hF;
            last_d  = 1'b1;
            state_d = S_TRL;
`else
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = S_IDLE;
`endif
          end
        end
      end

`ifdef JFB_CHECKSUM_EN
      S_TRL: begin
        m_valid = 1'b1;
        if (m_ready) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = S_IDLE;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      n_q         <= 3'd0;
      seq_q       <= 8'd0;
      data_q      <= 32'd0;
      keep_q      <= 4'd0;
      last_q      <= 1'b0;
      frame_cnt_q <= 16'd0;
`ifdef JFB_CHECKSUM_EN
      sum_q       <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      n_q         <= n_d;
      seq_q       <= seq_d;
      data_q      <= data_d;
      keep_q      <= keep_d;
      last_q      <= last_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef JFB_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  // Word registers only change on entry to a presenting state, so they stay
  // stable while the consumer holds off m_ready.
  assign m_data    = data_q;
  assign m_keep    = keep_q;
  assign m_last    = last_q;
  assign frame_cnt = frame_cnt_q;

endmodule
